// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared sizes, state encoding and round-robin helper for led_blink_sched
package led_sched_pkg;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;
    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE
`ifdef LED_SCHED_GAP_EN
        , S_GAP
`endif
    } state_e;

    // Returns {valid, index}: first requester after ptr, wrapping, ptr itself last
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] req, input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   r;
        logic [IDX_W-1:0] j;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = ptr + IDX_W'(k);
            if (req[j]) r = {1'b1, j};
        end
        return r;
    endfunction

endpackage

// File: rtl/led_blink_sched_tick_gen.sv
// tick_gen: timebase prescaler, one-cycle tick every CLK_HZ/TICK_HZ cycles after clr_i
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Count up, restart on clear or after the terminal count
    always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_blink_sched.sv
// led_blink_sched: round-robin scheduler that blinks one LED for up to four requesters
// Optional LED_SCHED_GAP_EN inserts a GAP_TICKS LED-off gap after every sequence.
module led_blink_sched
    import led_sched_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int ON_TICKS  = 250,
    parameter int OFF_TICKS = 250,
    parameter int GAP_TICKS = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*CNT_W-1:0] blinks_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       done_o,
    output logic                  busy_o,
    output logic                  led_o
);

    localparam int PH_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_M = (PH_A > GAP_TICKS) ? PH_A : GAP_TICKS;
    localparam int PH_W = $clog2(PH_M + 1);
    localparam logic [PH_W-1:0] ON_END  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_END = PH_W'(OFF_TICKS - 1);
`ifdef LED_SCHED_GAP_EN
    localparam logic [PH_W-1:0] GAP_END = PH_W'(GAP_TICKS - 1);
    localparam state_e S_END = S_GAP;
`else
    localparam state_e S_END = S_IDLE;
`endif

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic              led_q, led_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, idx_q, idx_d;
    logic [IDX_W:0]    pick;
    logic              tick, clr, live;

    tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr),
        .tick_o(tick)
    );

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign led_o  = led_q;
    assign busy_o = (state_q != S_IDLE);
    assign pick   = rr_pick(req_i, ptr_q);
    assign live   = |(req_i & gnt_q);

    // Next-state, grant, blink timing and abort handling
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        led_d   = led_q;
        rem_d   = rem_q;
        ph_d    = ph_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick[IDX_W]) begin
                    idx_d = pick[IDX_W-1:0];
                    gnt_d = NREQ'(1) << pick[IDX_W-1:0];
                    rem_d = blinks_i[32'(pick[IDX_W-1:0])*CNT_W +: CNT_W];
                    ph_d  = '0;
                    clr   = 1'b1;
                    if (rem_d == '0) begin
                        state_d = S_DONE;
                        done_d  = gnt_d;
                    end else begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                    end
                end
            end
            S_ON, S_OFF: begin
                if (!live) begin
                    state_d = S_END;
                    led_d   = 1'b0;
                    gnt_d   = '0;
                    ptr_d   = idx_q;
                    ph_d    = '0;
                    clr     = 1'b1;
                end else if (tick && state_q == S_ON) begin
                    ph_d    = (ph_q == ON_END) ? '0 : ph_q + 1'b1;
                    state_d = (ph_q == ON_END) ? S_OFF : S_ON;
                    led_d   = (ph_q != ON_END);
                end else if (tick) begin
                    ph_d = (ph_q == OFF_END) ? '0 : ph_q + 1'b1;
                    if (ph_q == OFF_END) begin
                        rem_d   = rem_q - 1'b1;
                        state_d = (rem_d == '0) ? S_DONE : S_ON;
                        led_d   = (rem_d != '0);
                        done_d  = (rem_d == '0) ? gnt_q : '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_END;
                gnt_d   = '0;
                ptr_d   = idx_q;
                ph_d    = '0;
                clr     = 1'b1;
            end
`ifdef LED_SCHED_GAP_EN
            S_GAP: begin
                if (tick) begin
                    ph_d    = (ph_q == GAP_END) ? '0 : ph_q + 1'b1;
                    state_d = (ph_q == GAP_END) ? S_IDLE : S_GAP;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; pointer resets to the last index so requester 0 wins first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            led_q   <= 1'b0;
            rem_q   <= '0;
            ph_q    <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            led_q   <= led_d;
            rem_q   <= rem_d;
            ph_q    <= ph_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: doc/led_blink_sched.md
LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, timebase tick rate; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameters ON_TICKS, default 250, and OFF_TICKS, default 250, give the LED on and off time per blink in ticks; both SHALL be >= 1.
REQ-004 Parameter GAP_TICKS, default 1000, gives the inter-sequence LED-off gap in ticks; it is used only with LED_SCHED_GAP_EN.
REQ-005 clk_i  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 req_i  input  4  per-requester blink request, level, one bit per requester 0..3.
REQ-008 blinks_i  input  16  per-requester blink count, 4 bits each (requester n at [4n+3:4n]), range 0..15.
REQ-009 gnt_o  output  4  one-hot grant, registered; all zero when no requester owns the LED.
REQ-010 done_o  output  4  one-cycle completion pulse to the granted requester.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 led_o  output  1  registered LED drive.

Function
REQ-013 States SHALL be IDLE, ON, OFF, DONE and GAP; GAP SHALL exist only with LED_SCHED_GAP_EN.
REQ-014 In IDLE with any req_i high, the next edge SHALL grant one requester by round-robin, starting at the index after the last granted one (index 0 first after reset).
REQ-015 At the grant edge, the granted blinks_i field SHALL be latched into a remaining counter; a later blinks_i change SHALL be ignored.
REQ-016 If the latched count is 0, the state SHALL go straight to DONE with led_o kept low.
REQ-017 Otherwise the state SHALL go to ON with led_o=1, and the tick prescaler and tick-phase counter SHALL clear at that edge, so the first on period is exactly ON_TICKS*CLK_HZ/TICK_HZ cycles.
REQ-018 ON SHALL last ON_TICKS ticks and then go to OFF with led_o=0; OFF SHALL last OFF_TICKS ticks and then decrement the remaining counter.
REQ-019 When the decremented count is nonzero the state SHALL return to ON; when it is zero the state SHALL go to DONE.
REQ-020 DONE SHALL last one cycle: done_o[granted]=1 and the round-robin pointer updated, with gnt_o cleared on the next edge.
REQ-021 If the granted req_i falls before DONE, the sequence SHALL abort: next edge led_o=0, gnt_o=0, no done_o, pointer updated, state IDLE.
REQ-022 Requests arriving while busy SHALL wait; there is no preemption.
REQ-023 A request that is held SHALL be re-granted only after every other active requester has been served once.
REQ-024 gnt_o and done_o SHALL never have more than one bit set.

Reset
REQ-025 rst_i high SHALL immediately force state IDLE, led_o=0, gnt_o=0, done_o=0, busy_o=0, all counters 0 and the round-robin pointer to index 3 (so index 0 wins first).
REQ-026 Reset asserted mid-sequence SHALL behave identically, and no done_o SHALL be emitted for the aborted sequence.

Configuration
REQ-027 The feature macro SHALL be LED_SCHED_GAP_EN.
REQ-028 With LED_SCHED_GAP_EN defined, DONE and abort SHALL enter GAP (led_o=0, busy_o=1, gnt_o=0) for GAP_TICKS ticks, then return to IDLE.
REQ-029 Without LED_SCHED_GAP_EN, DONE and abort SHALL return directly to IDLE, and a new grant MAY occur on the following edge.

Structure
REQ-030 The state enum, NREQ=4 and CNT_W=4 SHALL live in package led_sched_pkg.
REQ-031 The prescaler SHALL be sub-module tick_gen (inputs clk_i, rst_i, clr_i; output tick_o, a one-cycle pulse every CLK_HZ/TICK_HZ cycles after clr_i).
REQ-032 The target RTL size is 150-300 lines in total.

Verification (bench uses CLK_HZ=10, TICK_HZ=1, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3)
REQ-033 Single blink: req_i=0001, blinks=2 -> gnt_o=0001 one cycle later; led_o high 20 cycles, low 10, high 20, low 10; then done_o=0001 for one cycle.
REQ-034 Zero count: req_i=0100, blinks=0 -> gnt_o=0100, done_o=0100 pulse, led_o never high.
REQ-035 Round-robin: req_i=1111 held, all blinks=1 -> grant order 0,1,2,3,0; no two gnt_o bits ever set.
REQ-036 Abort: requester 1 (blinks=3) drops req_i in the second ON period -> next edge led_o=0, gnt_o=0, no done_o.
REQ-037 Reset mid-ON: rst_i pulses during ON -> led_o=0, busy_o=0 immediately; after release, req_i=1000 and 0001 together -> requester 0 granted first.
REQ-038 Gap enabled (LED_SCHED_GAP_EN): after done_o, busy_o stays high with led_o=0 for 30 cycles before the next grant; without the macro the next grant comes 2 cycles after done_o.
